// File: rtl/tap_controller.sv
// tap_controller: IEEE 1149.1 TAP state machine with IR, bypass register and TDO mux.
// Define TAP_IDCODE_EN to add the 32-bit IDCODE register and make IDCODE the reset instruction.
module tap_controller
`ifdef TAP_IDCODE_EN
  #(parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001)
`endif
  (
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  input  logic       tdi_i,
  output logic       tdo_o,
  output logic       tdo_en_o,
  output logic [3:0] ir_o,
  input  logic       bypass_en_i,
  input  logic       dr_tdo_i,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic [3:0] tap_state_o,
  output logic       test_logic_reset_o
);
  localparam int IRW = 4;
  localparam logic [IRW-1:0] BYPASS = '1;
`ifdef TAP_IDCODE_EN
  localparam logic [IRW-1:0] IDCODE = 4'b0001;
  localparam logic [IRW-1:0] IR_RST = IDCODE;
`else
  localparam logic [IRW-1:0] IR_RST = BYPASS;
`endif

  typedef enum logic [3:0] {
    TLR      = 4'hF, RTI      = 4'hC,
    SEL_DR   = 4'h7, CAP_DR   = 4'h6, SH_DR    = 4'h2, EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3, EX2_DR   = 4'h0, UPD_DR   = 4'h5,
    SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR    = 4'hA, EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR   = 4'hD
  } state_e;

  state_e         state_q, state_d;
  logic [IRW-1:0] ir_sh_q, ir_sh_d, ir_q, ir_d;
  logic           bypass_q, bypass_d;
  logic           tdo_q, tdo_d, tdo_en_q, tdo_en_d;
  logic           dr_bit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      state_d = tms_i ? TLR      : RTI;
      RTI:      state_d = tms_i ? SEL_DR   : RTI;
      SEL_DR:   state_d = tms_i ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = tms_i ? EX1_DR   : SH_DR;
      SH_DR:    state_d = tms_i ? EX1_DR   : SH_DR;
      EX1_DR:   state_d = tms_i ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = tms_i ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_d = tms_i ? UPD_DR   : SH_DR;
      UPD_DR:   state_d = tms_i ? SEL_DR   : RTI;
      SEL_IR:   state_d = tms_i ? TLR      : CAP_IR;
      CAP_IR:   state_d = tms_i ? EX1_IR   : SH_IR;
      SH_IR:    state_d = tms_i ? EX1_IR   : SH_IR;
      EX1_IR:   state_d = tms_i ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = tms_i ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_d = tms_i ? UPD_IR   : SH_IR;
      UPD_IR:   state_d = tms_i ? SEL_DR   : RTI;
    endcase
  end

  always_comb begin
    ir_sh_d  = state_q == CAP_IR ? {{(IRW-2){1'b0}}, 2'b01}
             : state_q == SH_IR  ? {tdi_i, ir_sh_q[IRW-1:1]} : ir_sh_q;
    ir_d     = state_q == TLR    ? IR_RST
             : state_q == UPD_IR ? ir_sh_q : ir_q;
    bypass_d = state_q == CAP_DR ? 1'b0
             : state_q == SH_DR  ? tdi_i : bypass_q;
    tdo_d    = state_q == SH_IR  ? ir_sh_q[0]
             : state_q == SH_DR  ? dr_bit : 1'b0;
    tdo_en_d = state_q == SH_IR || state_q == SH_DR;
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_q, idcode_d;
  logic        id_sel;
  assign id_sel = ir_q == IDCODE;
  always_comb begin
    idcode_d = state_q == CAP_DR && id_sel ? {IDCODE_VALUE[31:1], 1'b1}
             : state_q == SH_DR  && id_sel ? {tdi_i, idcode_q[31:1]} : idcode_q;
  end
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) idcode_q <= '0;
    else          idcode_q <= idcode_d;
  end
  // IDCODE takes the DR path whenever it is the active instruction, regardless of the decoder
  assign dr_bit = id_sel ? idcode_q[0] : bypass_en_i ? bypass_q : dr_tdo_i;
`else
  assign dr_bit = bypass_en_i ? bypass_q : dr_tdo_i;
`endif

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q  <= TLR;
      ir_sh_q  <= '0;
      ir_q     <= IR_RST;
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_sh_q  <= ir_sh_d;
      ir_q     <= ir_d;
      bypass_q <= bypass_d;
    end
  end

  // TDO launches on the falling edge so the next device samples it half a cycle later
  always_ff @(negedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tdo_o              = tdo_q;
  assign tdo_en_o           = tdo_en_q;
  assign ir_o               = ir_q;
  assign tap_state_o        = state_q;
  assign capture_dr_o       = state_q == CAP_DR;
  assign shift_dr_o         = state_q == SH_DR;
  assign update_dr_o        = state_q == UPD_DR;
  assign test_logic_reset_o = state_q == TLR;
endmodule

// File: tb/tb_tap_controller.sv
// tb_tap_controller: directed, table-driven checks of the TAP FSM, IR/bypass/IDCODE paths and reset.
module tb_tap_controller;
  logic       tck_i = 1'b0, trst_ni = 1'b0, tms_i = 1'b1, tdi_i = 1'b0;
  logic       bypass_en_i = 1'b0, dr_tdo_i = 1'b0;
  logic       tdo_o, tdo_en_o, capture_dr_o, shift_dr_o, update_dr_o, test_logic_reset_o;
  logic [3:0] ir_o, tap_state_o;
  int         tests = 0, fails = 0;
  logic       s;
  logic [31:0] w;
`ifdef TAP_IDCODE_EN
  localparam logic [3:0] RST_IR = 4'h1;
`else
  localparam logic [3:0] RST_IR = 4'hF;
`endif

  typedef struct {logic tms; logic [3:0] st;} step_t;
  step_t walk [44];

  tap_controller dut (
    .tck_i(tck_i), .trst_ni(trst_ni), .tms_i(tms_i), .tdi_i(tdi_i),
    .tdo_o(tdo_o), .tdo_en_o(tdo_en_o), .ir_o(ir_o), .bypass_en_i(bypass_en_i),
    .dr_tdo_i(dr_tdo_i), .capture_dr_o(capture_dr_o), .shift_dr_o(shift_dr_o),
    .update_dr_o(update_dr_o), .tap_state_o(tap_state_o),
    .test_logic_reset_o(test_logic_reset_o)
  );

  initial forever #5 tck_i = ~tck_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick(input logic t, input logic d, output logic so);
    tms_i = t;
    tdi_i = d;
    @(negedge tck_i);
    #1 so = tdo_o;
    @(posedge tck_i);
    #1;
  endtask

  task automatic go(input logic [7:0] seq, input int n);
    logic x;
    for (int i = n - 1; i >= 0; i--) tick(seq[i], 1'b0, x);
  endtask

  task automatic rst_pulse;
    @(posedge tck_i);
    #1 trst_ni = 1'b0;
    #2 trst_ni = 1'b1;
  endtask

  initial begin
    walk = '{'{1,4'hF},'{0,4'hC},'{0,4'hC},'{1,4'h7},'{0,4'h6},'{1,4'h1},'{0,4'h3},'{0,4'h3},
             '{1,4'h0},'{0,4'h2},'{0,4'h2},'{1,4'h1},'{1,4'h5},'{1,4'h7},'{0,4'h6},'{0,4'h2},
             '{1,4'h1},'{0,4'h3},'{1,4'h0},'{1,4'h5},'{0,4'hC},'{1,4'h7},'{1,4'h4},'{0,4'hE},
             '{1,4'h9},'{0,4'hB},'{0,4'hB},'{1,4'h8},'{0,4'hA},'{0,4'hA},'{1,4'h9},'{1,4'hD},
             '{1,4'h7},'{1,4'h4},'{0,4'hE},'{0,4'hA},'{1,4'h9},'{0,4'hB},'{1,4'h8},'{1,4'hD},
             '{0,4'hC},'{1,4'h7},'{1,4'h4},'{1,4'hF}};

    // reset held across clock edges
    @(posedge tck_i);
    @(posedge tck_i);
    #1;
    chk("rst_state", tap_state_o, 4'hF);
    chk("rst_flags", {test_logic_reset_o, capture_dr_o, shift_dr_o, update_dr_o}, 4'b1000);
    chk("rst_tdo", {tdo_o, tdo_en_o}, 2'b00);
    chk("rst_ir", ir_o, RST_IR);
    #2 trst_ni = 1'b1;
    tick(1'b0, 1'b0, s);
    chk("first_edge_rti", tap_state_o, 4'hC);

    // all 32 arcs with state-decoded strobes
    rst_pulse();
    for (int i = 0; i < 44; i++) begin
      tick(walk[i].tms, 1'b1, s);
      chk($sformatf("walk%0d", i),
          {tap_state_o, capture_dr_o, shift_dr_o, update_dr_o, test_logic_reset_o},
          {walk[i].st, walk[i].st == 4'h6, walk[i].st == 4'h2, walk[i].st == 4'h5, walk[i].st == 4'hF});
    end

    // five TMS=1 clocks from every reachable state
    for (int i = 0; i < 44; i++) begin
      rst_pulse();
      for (int j = 0; j <= i; j++) tick(walk[j].tms, 1'b1, s);
      go(8'h1F, 5);
      chk($sformatf("five_ones%0d", i), tap_state_o, 4'hF);
    end

    // IR scan of 0000 from RTI
    rst_pulse();
    go(8'b0, 1);
    go(8'b1100, 4);
    chk("to_shir", tap_state_o, 4'hA);
    w = '0;
    for (int k = 0; k < 4; k++) begin
      tick(k == 3, 1'b0, s);
      w = {w[30:0], s};
    end
    chk("ir_scan_tdo", w[3:0], 4'b1000);
    go(8'b1, 1);
    chk("updir_state", tap_state_o, 4'hD);
    chk("ir_held", ir_o, RST_IR);
    go(8'b0, 1);
    chk("ir_loaded", ir_o, 4'h0);
    go(8'h1F, 5);
    chk("tlr_ir_reload", {tap_state_o, ir_o}, {4'hF, RST_IR});

    // pause resume: two bits, pause, two more bits
    rst_pulse();
    go(8'b01100, 5);
    w = '0;
    tick(1'b0, 1'b1, s); w = {w[30:0], s};
    tick(1'b1, 1'b0, s); w = {w[30:0], s};
    go(8'b000, 3);
    chk("pause_ir", tap_state_o, 4'hB);
    go(8'b1, 1);
    chk("ex2_ir", tap_state_o, 4'h8);
    go(8'b0, 1);
    chk("resume_shir", tap_state_o, 4'hA);
    tick(1'b0, 1'b1, s); w = {w[30:0], s};
    tick(1'b1, 1'b1, s); w = {w[30:0], s};
    chk("pause_tdo", w[3:0], 4'b1000);
    go(8'b10, 2);
    chk("pause_ir_value", ir_o, 4'hD);

    // reset mid-ShIR discards the partial shift
    go(8'b1100, 4);
    tick(1'b0, 1'b0, s);
    @(negedge tck_i);
    #1 chk("shir_en", tdo_en_o, 1'b1);
    #1 trst_ni = 1'b0;
    #1;
    chk("async_shir", {tap_state_o, ir_o, tdo_en_o}, {4'hF, RST_IR, 1'b0});
    rst_pulse();
    go(8'b0, 1);
    chk("post_rst_ir", {tap_state_o, ir_o}, {4'hC, RST_IR});

    // async reset mid-ShDR, no clock edge
    go(8'b100, 3);
    tick(1'b0, 1'b1, s);
    @(negedge tck_i);
    #1 chk("shdr_en", {tap_state_o, shift_dr_o, tdo_en_o}, {4'h2, 1'b1, 1'b1});
    #1 trst_ni = 1'b0;
    #1;
    chk("async_shdr", {tap_state_o, shift_dr_o, tdo_en_o, ir_o}, {4'hF, 1'b0, 1'b0, RST_IR});

`ifdef TAP_IDCODE_EN
    rst_pulse();
    go(8'b0100, 4);
    w = '0;
    for (int k = 0; k < 32; k++) begin
      tick(k == 31, 1'b0, s);
      w[k] = s;
    end
    chk("idcode", w, 32'h1000_0001);
`else
    // bypass: 10110011 reappears one clock late behind a leading 0
    rst_pulse();
    bypass_en_i = 1'b1;
    go(8'b0100, 4);
    chk("to_shdr", tap_state_o, 4'h2);
    w = '0;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] pat;
      pat = 8'b1011_0011;
      tick(k == 8, k < 8 ? pat[7-k] : 1'b0, s);
      w = {w[30:0], s};
    end
    chk("bypass_tdo", w[8:0], 9'b0_1011_0011);
    tick(1'b1, 1'b0, s);
    chk("ex1dr_tdo", {s, tdo_en_o}, 2'b00);

    // same DR entry as IDCODE would use: single 0 then the tdi stream
    rst_pulse();
    go(8'b0100, 4);
    w = '0;
    for (int k = 0; k < 32; k++) begin
      logic [31:0] p;
      p = 32'hC3A5_1E69;
      tick(k == 31, p[k], s);
      w[k] = s;
    end
    chk("no_idcode", w, 32'h874A_3CD2);

    // external DR path
    rst_pulse();
    bypass_en_i = 1'b0;
    go(8'b0100, 4);
    dr_tdo_i = 1'b1;
    tick(1'b0, 1'b0, s);
    chk("dr_tdo_1", s, 1'b1);
    dr_tdo_i = 1'b0;
    tick(1'b0, 1'b1, s);
    chk("dr_tdo_0", s, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 Parameter IDCODE_VALUE, default 32'h1000_0001, meaning device ID; bit 0 is always 1.
REQ-002 Port tck_i  input  1  TAP clock (TCK), the only clock.
REQ-003 Port trst_ni  input  1  TAP reset, asynchronous, active-low.
REQ-004 Port tms_i  input  1  test mode select, sampled on tck_i rising edge.
REQ-005 Port tdi_i  input  1  serial data in, sampled on tck_i rising edge.
REQ-006 Port tdo_o  output  1  serial data out, driven on tck_i falling edge.
REQ-007 Port tdo_en_o  output  1  TDO output enable for the pad.
REQ-008 Port ir_o  output  instruction_width (tap_pkg, 4)  active instruction, fed to the instruction decoder.
REQ-009 Port bypass_en_i  input  1  bypass select, returned from the decoder.
REQ-010 Port dr_tdo_i  input  1  serial output of the external data register (BSR).
REQ-011 Port capture_dr_o, shift_dr_o, update_dr_o  output  1 each  DR strobes to the BSR.
REQ-012 Port tap_state_o  output  4  current FSM state.
REQ-013 Port test_logic_reset_o  output  1  high while in Test-Logic-Reset.

Function
REQ-014 16-state IEEE 1149.1 FSM, 4-bit encoding: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
REQ-015 Transitions on tck_i rising edge (TMS=0 : TMS=1): TLR RTI:TLR; RTI RTI:SelDR; SelDR CapDR:SelIR; SelIR CapIR:TLR; Cap ShX:Ex1X; Sh ShX:Ex1X; Ex1 PauseX:UpdX; Pause PauseX:Ex2X; Ex2 ShX:UpdX; Upd RTI:SelDR (X = DR or IR branch).
REQ-016 Five consecutive TMS=1 clocks from any state shall reach TLR.
REQ-017 IR shift register: CapIR loads {zeros, 2'b01}; ShIR shifts right, tdi_i into MSB.
REQ-018 ir_o loads the IR shift register on the rising edge at which state is UpdIR; ir_o is held otherwise.
REQ-019 In TLR, ir_o = BYPASS (4'b1111) on every rising edge.
REQ-020 Bypass register, 1 bit: cleared in CapDR; loads tdi_i in ShDR.
REQ-021 capture_dr_o, shift_dr_o, update_dr_o decode only the state register, with no combinational path from tms_i.
REQ-022 TDO source: ShIR -> IR shift[0]; ShDR with bypass_en_i=1 -> bypass bit; ShDR with bypass_en_i=0 -> dr_tdo_i; all other states -> 0.
REQ-023 tdo_o and tdo_en_o register on the falling edge of tck_i; tdo_en_o = 1 only in ShIR or ShDR.
REQ-024 Shift length is unbounded; Pause/Ex2 then return to Shift resumes without loss of bits.

Reset
REQ-025 trst_ni low asynchronously forces: state TLR; ir_o 4'b1111; IR shift 0; bypass 0; tdo_o 0; tdo_en_o 0.
REQ-026 While trst_ni is low: strobes are 0, test_logic_reset_o is 1, and tap_state_o is 4'hF.
REQ-027 Reset mid-shift discards partial IR contents; ir_o does not load the partial value.
REQ-028 After deassertion, the first rising edge evaluates tms_i from TLR.

Configuration
REQ-029 Macro TAP_IDCODE_EN adds a 32-bit IDCODE register and instruction IDCODE = 4'b0001.
REQ-030 With TAP_IDCODE_EN: CapDR with ir_o=IDCODE loads IDCODE_VALUE; ShDR shifts right with TDO = bit 0; TLR and reset load ir_o = IDCODE.
REQ-031 Without TAP_IDCODE_EN: no IDCODE logic is present; 4'b0001 is treated as any decoder-defined code; TLR and reset value stay BYPASS.

Verification
REQ-032 Async reset: trst_ni low mid-ShDR -> tap_state_o=F, tdo_en_o=0, ir_o=4'hF immediately, without a clock edge.
REQ-033 TMS sequence 1,1,0,0 from RTI reaching ShIR, then shift tdi 0,0,0,0 (last bit with TMS=1), then TMS 1,0 -> ir_o=4'h0 after UpdIR; TDO showed 1,0,0,0.
REQ-034 BYPASS: ir_o=F, bypass_en_i=1, shift 8 bits 10110011 -> TDO reproduces the pattern delayed 1 clock, first bit 0.
REQ-035 From each of the 16 states, 5 clocks of TMS=1 -> TLR; full transition table exercised with coverage on all 32 arcs.
REQ-036 TAP_IDCODE_EN: reset, TMS 0,1,0,0 then 32 shifts -> TDO = 32'h1000_0001 LSB-first; without the macro, the same sequence yields a single 0 then the tdi stream.
REQ-037 Pause resume: ShIR 2 bits, enter PauseIR for 3 clocks, return via Ex2IR, shift 2 bits -> ir_o equals all 4 bits in order.
